mem_arbiter: RTL

- Shares the single-ported RAM between the instruction-fetch path (iREN/iaddr) and the data path (dREN/dWEN from decode).
- Holds a registered grant across multi-cycle RAM latency and returns wait/load to each requester.
- Data accesses have priority, bounded by an anti-starvation counter for fetch.
- Detects RAM error and a hung-access timeout.

---
 rtl/cpu_types_pkg.sv | 7 +
 rtl/mem_types_pkg.sv | 11 +
 rtl/arb_timeout_counter.sv | 25 ++
 rtl/mem_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side enums: RAM handshake state and the memory arbiter grant state.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGNT, DGNT, ERR} arb_state_t;

endpackage

// File: rtl/mem_types_pkg.sv
// Memory-subsystem defaults and sizing helper shared by the arbiter and its counters.
package mem_types_pkg;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT    = 255;

    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Grant-age counter: load clears, enable advances, tc flags the cycle that would reach LIMIT.
module arb_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int W     = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic load,
    input  logic en,
    output logic tc
);
    logic [W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count <= '0;
        else if (load)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and data paths; data wins, fetch is protected from
// starvation. Optional MEM_ARB_PERF_EN adds completion and stall counters.
module mem_arbiter
    import cpu_types_pkg::*;
    import mem_types_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  ramstate_t   ramstate,
    input  logic [31:0] ramload,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        err
`ifdef MEM_ARB_PERF_EN
   ,output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] stall_cycles
`endif
);
    localparam int TW = cntWidth(TIMEOUT);
    localparam int SW = cntWidth(STARVE_MAX);

    arb_state_t    state;
    logic [SW-1:0] starveCnt;
    logic          dReq, access, grant, held, iDone, dDone, tmoTc;

    assign dReq   = dREN | dWEN;
    assign access = (ramstate == ACCESS);
    assign grant  = (state == IGNT) || (state == DGNT);
    assign held   = ((state == IGNT) && iREN) || ((state == DGNT) && dReq);
    assign iDone  = (state == IGNT) && access;
    assign dDone  = (state == DGNT) && access;

    arb_timeout_counter #(.LIMIT(TIMEOUT), .W(TW)) uTmo (
        .CLK  (CLK),
        .nRST (nRST),
        .load (!grant),
        .en   (grant && !access),
        .tc   (tmoTc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            starveCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dReq && !(iREN && starveCnt == SW'(STARVE_MAX)))
                        state <= DGNT;
                    else if (iREN)
                        state <= IGNT;
                end
                IGNT, DGNT: begin
                    if (ramstate == ERROR) begin
                        state <= ERR;
                    end else if (access) begin
                        // Always return through IDLE so a request held one cycle too long is not re-served.
                        state <= IDLE;
                        if (state == IGNT || !iREN)
                            starveCnt <= '0;
                        else if (starveCnt != SW'(STARVE_MAX))
                            starveCnt <= starveCnt + 1'b1;
                    end else if (!held) begin
                        state <= IDLE;
                    end else if (tmoTc) begin
                        state <= ERR;
                    end
                end
                default: state <= ERR;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: ;
        endcase
    end

    assign iwait = !iDone;
    assign dwait = !dDone;
    assign iload = iDone ? ramload : '0;
    assign dload = dDone ? ramload : '0;
    assign err   = (state == ERR);

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount       <= '0;
            dcount       <= '0;
            stall_cycles <= '0;
        end else begin
            if (iDone) icount <= icount + 1'b1;
            if (dDone) dcount <= dcount + 1'b1;
            if ((iwait && iREN) || (dwait && dReq))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule
